winograd_output_transform_6x6: RTL and testbench

- Output-transform stage of the Winograd F(4x4,3x3) datapath. Sits directly downstream of the 6x6 pointwise-multiply stage.
- Takes one 6x6 tile of signed 64-bit elementwise products M and computes the 4x4 output tile Y = A^T·M·A.
- Uses a single shared 1-D transform unit, time-multiplexed over a column pass and then a row pass.
- Its result feeds output-tile accumulation and write-back.

---
 rtl/winograd_pkg.sv | 51 +++++
 rtl/winograd_output_transform_6x6_at_1d.sv | 31 +++
 rtl/winograd_output_transform_6x6.sv | 114 +++++++++++
 tb/tb_winograd_output_transform_6x6.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared constants, tile types, FSM states and the ACC_W -> OUT_W conversion
// for the Winograd F(4x4,3x3) output transform.
// Optional build macro: WINO_OUT_SAT_EN (saturate instead of wrap on output).
package winograd_pkg;

    localparam int IN_W     = 64;
    localparam int OUT_W    = 64;
    localparam int ACC_W    = IN_W + 10;
    localparam int TILE_IN  = 6;
    localparam int TILE_OUT = 4;

    // A^T rows; every coefficient is 0, +-1 or +-2^k so the 1-D unit is shift/add only
    localparam int AT_COEF [TILE_OUT][TILE_IN] = '{
        '{1, 1,  1, 1,  1, 0},
        '{0, 1, -1, 2, -2, 0},
        '{0, 1,  1, 4,  4, 0},
        '{0, 1, -1, 8, -8, 1}
    };

`ifdef WINO_OUT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef logic signed [IN_W-1:0]  in_tile_t  [TILE_IN][TILE_IN];
    typedef logic signed [OUT_W-1:0] out_tile_t [TILE_OUT][TILE_OUT];
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef acc_t                    acc_mid_t  [TILE_OUT][TILE_IN];
    typedef acc_t                    acc_vec6_t [TILE_IN];
    typedef acc_t                    acc_vec4_t [TILE_OUT];

    typedef enum logic [1:0] {
        IDLE,
        COLP,
        ROWP,
        DONE
    } state_t;

    // Narrow an ACC_W result to OUT_W: wrap by default, clamp when saturation is built in
    function automatic logic signed [OUT_W-1:0] to_out(input acc_t v);
        logic [ACC_W-OUT_W:0] top;
        top = v[ACC_W-1:OUT_W-1];
        if (SAT_EN && !((top == '0) || (top == '1))) begin
            to_out = v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            to_out = v[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/winograd_output_transform_6x6_at_1d.sv
// Combinational 1-D A^T transform: six ACC_W inputs to four ACC_W outputs,
// shared by the column pass and the row pass.
module winograd_at_1d
    import winograd_pkg::*;
(
    input  acc_vec6_t x,
    output acc_vec4_t o
);

    // Table-driven shift/add sum; coefficients are constants so this folds to fixed adders
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        o = '{default: '0};
        for (int r = 0; r < TILE_OUT; r++) begin
            for (int c = 0; c < TILE_IN; c++) begin
                case (AT_COEF[r][c])
                    1:       o[r] = o[r] + x[c];
                    -1:      o[r] = o[r] - x[c];
                    2:       o[r] = o[r] + (x[c] <<< 1);
                    -2:      o[r] = o[r] - (x[c] <<< 1);
                    4:       o[r] = o[r] + (x[c] <<< 2);
                    -4:      o[r] = o[r] - (x[c] <<< 2);
                    8:       o[r] = o[r] + (x[c] <<< 3);
                    -8:      o[r] = o[r] - (x[c] <<< 3);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/winograd_output_transform_6x6.sv
// Winograd F(4x4,3x3) output transform Y = A^T * M * A on one 6x6 tile.
// One shared 1-D unit: 6 column cycles build T = A^T*M, 4 row cycles build Y.
// Optional build macro: WINO_OUT_SAT_EN (saturating OUT_W conversion).
module winograd_output_transform_6x6
    import winograd_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  in_tile_t  m,
    output out_tile_t y,
    output logic      busy,
    output logic      done
);

    state_t     state;
    logic [2:0] cnt;
    in_tile_t   m_reg;
    acc_mid_t   t_reg;
    acc_vec6_t  x;
    acc_vec4_t  o;
    logic       accept;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Select the 1-D unit input: column cnt of M (sign-extended) or row cnt of T
    always_comb begin
        x = '{default: '0};
        for (int i = 0; i < TILE_IN; i++) begin
            if (state == ROWP) begin
                x[i] = t_reg[cnt[1:0]][i];
            end else begin
                x[i] = {{(ACC_W-IN_W){m_reg[i][cnt][IN_W-1]}}, m_reg[i][cnt]};
            end
        end
    end

    winograd_at_1d u_at_1d (
        .x (x),
        .o (o)
    );

    // Sequencer: IDLE -> COLP(6) -> ROWP(4) -> DONE(1), with registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // NOTE: state registers use <= so every flop samples pre-edge values, independent of statement order.
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    cnt <= '0;
                    if (start) begin
                        state <= COLP;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                COLP: begin
                    if (cnt == 3'd5) begin
                        cnt   <= '0;
                        state <= ROWP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ROWP: begin
                    if (cnt == 3'd3) begin
                        cnt   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: capture the tile, store T column by column, write y row by row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register banks are cleared on reset because a reset must leave no stale tile data visible.
            m_reg <= '{default: '0};
            t_reg <= '{default: '0};
            y     <= '{default: '0};
        end else begin
            if (accept) begin
                m_reg <= m;
            end
            if (state == COLP) begin
                for (int r = 0; r < TILE_OUT; r++) begin
                    t_reg[r][cnt] <= o[r];
                end
            end
            if (state == ROWP) begin
                for (int j = 0; j < TILE_OUT; j++) begin
                    y[cnt[1:0]][j] <= to_out(o[j]);
                end
            end
        end
    end

endmodule

// File: tb/tb_winograd_output_transform_6x6.sv
// Directed self-checking bench for winograd_output_transform_6x6.
// Expected tiles are hand-computed; WINO_OUT_SAT_EN selects the overflow expectations.
module tb_winograd_output_transform_6x6;
    import winograd_pkg::*;

    logic      clk;
    logic      rst;
    logic      start;
    in_tile_t  m;
    out_tile_t y;
    logic      busy;
    logic      done;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic signed [63:0] P62  = 64'sh4000_0000_0000_0000;
    localparam logic signed [63:0] N62  = 64'shC000_0000_0000_0000;
    localparam logic signed [63:0] MAXP = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [63:0] MINN = 64'sh8000_0000_0000_0000;

    winograd_output_transform_6x6 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_y(input string tag, input out_tile_t exp);
        for (int i = 0; i < TILE_OUT; i++) begin
            for (int j = 0; j < TILE_OUT; j++) begin
                check($sformatf("%s_y%0d%0d", tag, i, j), y[i][j], exp[i][j]);
            end
        end
    endtask

    // Presents tile t with start=1 now, then counts edges until done (bounded).
    // Optionally re-pulses start with poke_t after edge number poke_at.
    task automatic run_tile(input in_tile_t t, input int poke_at, input in_tile_t poke_t,
                            output int cyc, output int busy_cnt);
        m        = t;
        start    = 1'b1;
        cyc      = 0;
        busy_cnt = 0;
        while (cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (cyc == poke_at) begin
                m     = poke_t;
                start = 1'b1;
            end
            if (busy) busy_cnt++;
            if (done) break;
        end
    endtask

    task automatic watch_no_done(input string tag);
        int extra;
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check(tag, extra, 0);
    endtask

    in_tile_t  t_ones, t_zero, t_imp55, t_neg33, t_ovp, t_ovn;
    out_tile_t e_ones, e_zero, e_imp55, e_neg33, e_ovp, e_ovn;
    int cyc, bc;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        m     = '{default: '0};

        t_zero  = '{default: '0};
        t_ones  = '{default: 64'sd1};
        t_imp55 = '{default: '0};  t_imp55[5][5] = 64'sd1;
        t_neg33 = '{default: '0};  t_neg33[3][3] = -64'sd1;
        t_ovp   = '{default: '0};  t_ovp[3][3]   = P62;
        t_ovn   = '{default: '0};  t_ovn[3][3]   = N62;

        e_zero  = '{default: '0};
        e_ones  = '{'{25, 0, 50, 5}, '{0, 0, 0, 0}, '{50, 0, 100, 10}, '{5, 0, 10, 1}};
        e_imp55 = '{default: '0};  e_imp55[3][3] = 64'sd1;
        e_neg33 = '{'{-1, -2, -4, -8}, '{-2, -4, -8, -16}, '{-4, -8, -16, -32}, '{-8, -16, -32, -64}};
`ifdef WINO_OUT_SAT_EN
        e_ovp = '{default: MAXP};  e_ovp[0][0] = P62;
        e_ovn = '{default: MINN};  e_ovn[0][0] = N62;
`else
        e_ovp = '{default: '0};
        e_ovp[0][0] = P62;  e_ovp[0][1] = MINN;  e_ovp[1][0] = MINN;
        e_ovn = '{default: '0};
        e_ovn[0][0] = N62;  e_ovn[0][1] = MINN;  e_ovn[1][0] = MINN;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_y("rst", e_zero);
        @(negedge clk);
        rst = 1'b0;

        // All-ones tile: latency, busy window, result
        @(negedge clk);
        run_tile(t_ones, 0, t_zero, cyc, bc);
        check("ones_done", done, 1);
        check("ones_lat", cyc, 11);
        check("ones_busy_cycles", bc, 10);
        check("ones_busy_in_done", busy, 0);
        check_y("ones", e_ones);

        // Back-to-back start in the DONE cycle
        run_tile(t_imp55, 0, t_zero, cyc, bc);
        check("b2b_done", done, 1);
        check("b2b_lat", cyc, 11);
        check("b2b_busy_cycles", bc, 10);
        check_y("imp55", e_imp55);

        // Start pulse at cycle 4 is ignored; captured tile undisturbed
        @(negedge clk);
        run_tile(t_neg33, 4, t_ones, cyc, bc);
        check("ign_done", done, 1);
        check("ign_lat", cyc, 11);
        check_y("neg33", e_neg33);
        watch_no_done("ign_no_extra_done");
        check_y("neg33_hold", e_neg33);

        // Overflow, positive and negative
        @(negedge clk);
        run_tile(t_ovp, 0, t_zero, cyc, bc);
        check("ovp_lat", cyc, 11);
        check_y("ovp", e_ovp);
        @(negedge clk);
        run_tile(t_ovn, 0, t_zero, cyc, bc);
        check("ovn_lat", cyc, 11);
        check_y("ovn", e_ovn);

        // Reset during ROWP cycle 2 (state after the 9th edge)
        @(negedge clk);
        m     = t_ones;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check_y("mid_rst", e_zero);
        @(negedge clk);
        rst = 1'b0;
        watch_no_done("mid_rst_no_done");

        // Recovery after reset
        @(negedge clk);
        run_tile(t_neg33, 0, t_zero, cyc, bc);
        check("post_rst_done", done, 1);
        check("post_rst_lat", cyc, 11);
        check_y("post_rst", e_neg33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
